n_tap_fir_mc: RTL



---
 rtl/n_tap_fir_mc.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/n_tap_fir_mc.sv
// Multi-channel time-multiplexed FIR: one shared coefficient set, CHANNELS delay lines,
// a single sequential MAC over LENGTH cycles, then shift, saturate and strobe the result.
module n_tap_fir_mc #(
  parameter int LENGTH      = 20,
  parameter int DATA_WIDTH  = 8,
  parameter int COEFF_WIDTH = 8,
  parameter int CHANNELS    = 2,
  parameter int OUT_WIDTH   = 24,
  parameter int SHIFT       = 0,
  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   coeffStart,
  input  logic                   coeffValid,
  input  logic [COEFF_WIDTH-1:0] coeffIn,
  input  logic                   inValid,
  output logic                   inReady,
  input  logic [CH_W-1:0]        inChannel,
  input  logic [DATA_WIDTH-1:0]  dataIn,
  output logic                   outValid,
  output logic [CH_W-1:0]        outChannel,
  output logic [OUT_WIDTH-1:0]   dataOut,
  output logic                   satFlag,
  output logic                   chanError,
  output logic                   coeffLoaded,
  output logic [2:0]             fsm_state
);

  // Handshake: a sample transfers on a rising edge where inValid and inReady are both high.
  // inReady is high only in RUN; outValid is a one-cycle strobe with no backpressure.

  localparam int ACC_WIDTH = DATA_WIDTH + COEFF_WIDTH + $clog2(LENGTH);
  localparam int K_W       = $clog2(LENGTH);
  localparam int SAT_W     = ((ACC_WIDTH > OUT_WIDTH) ? ACC_WIDTH : OUT_WIDTH) + 1;
  localparam logic signed [SAT_W-1:0] MAX_V = {{(SAT_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [SAT_W-1:0] MIN_V = {{(SAT_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
  localparam logic [K_W-1:0] LAST_TAP = K_W'(LENGTH - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD_COEFF = 3'd1,
    RUN        = 3'd2,
    MAC        = 3'd3,
    OUTPUT     = 3'd4
  } state_t;

  state_t                          state;
  logic [K_W-1:0]                  tap;
  logic [CH_W-1:0]                 ch;
  logic signed [COEFF_WIDTH-1:0]   h [LENGTH];
  logic signed [DATA_WIDTH-1:0]    x [CHANNELS][LENGTH];
  logic signed [ACC_WIDTH-1:0]     acc;
  logic signed [DATA_WIDTH+COEFF_WIDTH-1:0] prod;
  logic signed [SAT_W-1:0]         r;
  logic                            chan_ok;
  logic                            state_legal;

  assign fsm_state   = state;
  assign chan_ok     = (int'(inChannel) < CHANNELS);
  assign state_legal = (state == IDLE) || (state == LOAD_COEFF) || (state == RUN) ||
                       (state == MAC) || (state == OUTPUT);
  assign prod        = x[ch][tap] * h[tap];
  assign r           = SAT_W'(acc) >>> SHIFT;

  // An illegal encoding is treated exactly like reset so the block never resumes mid-operation.
  always_ff @(posedge clock) begin
    if (reset || !state_legal) begin
      state       <= IDLE;
      tap         <= '0;
      ch          <= '0;
      acc         <= '0;
      inReady     <= 1'b0;
      outValid    <= 1'b0;
      outChannel  <= '0;
      dataOut     <= '0;
      satFlag     <= 1'b0;
      chanError   <= 1'b0;
      coeffLoaded <= 1'b0;
      for (int k = 0; k < LENGTH; k++) h[k] <= '0;
      for (int c = 0; c < CHANNELS; c++)
        for (int k = 0; k < LENGTH; k++) x[c][k] <= '0;
    end else begin
      outValid  <= 1'b0;
      satFlag   <= 1'b0;
      chanError <= 1'b0;
      case (state)
        IDLE: begin
          inReady <= 1'b0;
          if (coeffStart) begin
            state       <= LOAD_COEFF;
            tap         <= '0;
            coeffLoaded <= 1'b0;
          end
        end
        LOAD_COEFF: begin
          if (coeffValid) begin
            h[tap] <= coeffIn;
            if (tap == LAST_TAP) begin
              tap         <= '0;
              coeffLoaded <= 1'b1;
              inReady     <= 1'b1;
              state       <= RUN;
              for (int c = 0; c < CHANNELS; c++)
                for (int k = 0; k < LENGTH; k++) x[c][k] <= '0;
            end else begin
              tap <= tap + 1'b1;
            end
          end
        end
        RUN: begin
          if (coeffStart) begin
            state       <= LOAD_COEFF;
            inReady     <= 1'b0;
            tap         <= '0;
            coeffLoaded <= 1'b0;
          end else if (inValid && inReady) begin
            if (chan_ok) begin
              for (int k = 1; k < LENGTH; k++) x[inChannel][k] <= x[inChannel][k-1];
              x[inChannel][0] <= dataIn;
              ch      <= inChannel;
              acc     <= '0;
              tap     <= '0;
              inReady <= 1'b0;
              state   <= MAC;
            end else begin
              chanError <= 1'b1;
            end
          end
        end
        MAC: begin
          acc <= acc + ACC_WIDTH'(prod);
          if (tap == LAST_TAP) begin
            tap   <= '0;
            state <= OUTPUT;
          end else begin
            tap <= tap + 1'b1;
          end
        end
        OUTPUT: begin
          outValid   <= 1'b1;
          outChannel <= ch;
          if (r > MAX_V) begin
            dataOut <= MAX_V[OUT_WIDTH-1:0];
            satFlag <= 1'b1;
          end else if (r < MIN_V) begin
            dataOut <= MIN_V[OUT_WIDTH-1:0];
            satFlag <= 1'b1;
          end else begin
            dataOut <= r[OUT_WIDTH-1:0];
          end
          inReady <= 1'b1;
          state   <= RUN;
        end
        default: ;
      endcase
    end
  end

endmodule
